// File: rtl/traffic_light_sequencer.sv
// Four-phase row/column intersection sequencer with pause freeze and row-priority emergency.
// Outputs are registered one clock behind the state; no backpressure, time advances on tick & ~pause.
module traffic_light_sequencer #(
    parameter int GREEN_TICKS  = 28,
    parameter int YELLOW_TICKS = 4,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       pause,
    input  logic                       emergency,
    output logic [2:0]                 row_lights,
    output logic [2:0]                 column_lights,
    output logic [CNT_WIDTH-1:0]       row_count,
    output logic [CNT_WIDTH-1:0]       column_count,
    output logic [1:0]                 phase,
    output logic                       phase_done,
    output logic [6+2*CNT_WIDTH-1:0]   status
);

    if (GREEN_TICKS < 1 || GREEN_TICKS > (2**CNT_WIDTH) - 1) begin : g_bad_green
        $error("GREEN_TICKS must lie in 1 .. 2**CNT_WIDTH-1");
    end
    if (YELLOW_TICKS < 1 || YELLOW_TICKS > (2**CNT_WIDTH)) begin : g_bad_yellow
        $error("YELLOW_TICKS must lie in 1 .. 2**CNT_WIDTH");
    end

    typedef enum logic [1:0] {
        ROW_G = 2'd0,
        ROW_Y = 2'd1,
        COL_G = 2'd2,
        COL_Y = 2'd3
    } state_t;

    localparam logic [2:0] LT_GREEN  = 3'b001;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_RED    = 3'b100;

    localparam logic [CNT_WIDTH-1:0] G_LAST = CNT_WIDTH'(GREEN_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] Y_LAST = CNT_WIDTH'(YELLOW_TICKS - 1);

    state_t               state_q, state_d;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] elapsed_q, elapsed_d;
    logic [CNT_WIDTH-1:0] elapsed_inc;
    logic [CNT_WIDTH-1:0] dur_last;
    logic                 adv;

    logic [2:0]           row_lights_q, row_lights_d;
    logic [2:0]           column_lights_q, column_lights_d;
    logic [CNT_WIDTH-1:0] row_count_q, row_count_d;
    logic [CNT_WIDTH-1:0] column_count_q, column_count_d;
    logic [1:0]           phase_q, phase_d;
    logic                 phase_done_q, phase_done_d;

    always_comb begin
        adv         = tick & ~pause;
        elapsed_inc = elapsed_q + CNT_WIDTH'(1);
        dur_last    = (state_q == ROW_G || state_q == COL_G) ? G_LAST : Y_LAST;

        case (state_q)
            ROW_G:   state_next = ROW_Y;
            ROW_Y:   state_next = COL_G;
            COL_G:   state_next = COL_Y;
            default: state_next = ROW_G;
        endcase

        state_d      = state_q;
        elapsed_d    = elapsed_q;
        phase_done_d = 1'b0;

        // Emergency parks row green at its last count; column green is cut short.
        if (adv) begin
            if (state_q == ROW_G && emergency && elapsed_q == G_LAST) begin
                elapsed_d = elapsed_q;
            end else if (elapsed_q == dur_last || (state_q == COL_G && emergency)) begin
                state_d      = state_next;
                elapsed_d    = '0;
                phase_done_d = 1'b1;
            end else begin
                elapsed_d = elapsed_inc;
            end
        end
    end

    always_comb begin
        row_lights_d    = LT_GREEN;
        column_lights_d = LT_RED;
        case (state_q)
            ROW_G: begin
                row_lights_d    = LT_GREEN;
                column_lights_d = LT_RED;
            end
            ROW_Y: begin
                row_lights_d    = LT_YELLOW;
                column_lights_d = LT_RED;
            end
            COL_G: begin
                row_lights_d    = LT_RED;
                column_lights_d = LT_GREEN;
            end
            default: begin
                row_lights_d    = LT_RED;
                column_lights_d = LT_YELLOW;
            end
        endcase

        phase_d = state_q;

        // A count shows ticks taken so far in its green phase, including the tick on this edge.
        row_count_d = '0;
        if (state_q == ROW_G) begin
            row_count_d = adv ? elapsed_inc : row_count_q;
        end
        column_count_d = '0;
        if (state_q == COL_G) begin
            column_count_d = adv ? elapsed_inc : column_count_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ROW_G;
            elapsed_q       <= '0;
            row_lights_q    <= '0;
            column_lights_q <= '0;
            row_count_q     <= '0;
            column_count_q  <= '0;
            phase_q         <= '0;
            phase_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            elapsed_q       <= elapsed_d;
            row_lights_q    <= row_lights_d;
            column_lights_q <= column_lights_d;
            row_count_q     <= row_count_d;
            column_count_q  <= column_count_d;
            phase_q         <= phase_d;
            phase_done_q    <= phase_done_d;
        end
    end

    assign row_lights    = row_lights_q;
    assign column_lights = column_lights_q;
    assign row_count     = row_count_q;
    assign column_count  = column_count_q;
    assign phase         = phase_q;
    assign phase_done    = phase_done_q;
    assign status        = {row_lights_q, column_lights_q, row_count_q, column_count_q};

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer: every edge is scored against a queued expectation.
module tb_traffic_light_sequencer;

    localparam int G = 28;
    localparam int Y = 4;
    localparam int W = 8;

    localparam int ROWL [4] = '{1, 2, 4, 4};
    localparam int COLL [4] = '{4, 4, 1, 2};

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             tick = 1'b0;
    logic             pause = 1'b0;
    logic             emergency = 1'b0;
    logic [2:0]       row_lights;
    logic [2:0]       column_lights;
    logic [W-1:0]     row_count;
    logic [W-1:0]     column_count;
    logic [1:0]       phase;
    logic             phase_done;
    logic [6+2*W-1:0] status;

    typedef struct {
        logic [6+2*W-1:0] status;
        logic [1:0]       phase;
        logic             done;
    } exp_t;

    exp_t sb [$];

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    int m_ph = 0;
    int m_el = 0;
    int m_rc = 0;
    int m_cc = 0;

    traffic_light_sequencer #(
        .GREEN_TICKS  (G),
        .YELLOW_TICKS (Y),
        .CNT_WIDTH    (W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .tick          (tick),
        .pause         (pause),
        .emergency     (emergency),
        .row_lights    (row_lights),
        .column_lights (column_lights),
        .row_count     (row_count),
        .column_count  (column_count),
        .phase         (phase),
        .phase_done    (phase_done),
        .status        (status)
    );

    always #5 clock = ~clock;

    task automatic model(input logic r, input logic t, input logic p, input logic e, output exp_t x);
        bit adv;
        int dur;
        if (r) begin
            m_ph = 0;
            m_el = 0;
            m_rc = 0;
            m_cc = 0;
            x.status = '0;
            x.phase  = 2'd0;
            x.done   = 1'b0;
        end else begin
            adv = t && !p;
            dur = (m_ph == 0 || m_ph == 2) ? G : Y;
            m_rc = (m_ph != 0) ? 0 : (adv ? m_el + 1 : m_rc);
            m_cc = (m_ph != 2) ? 0 : (adv ? m_el + 1 : m_cc);
            x.status = {3'(ROWL[m_ph]), 3'(COLL[m_ph]), 8'(m_rc), 8'(m_cc)};
            x.phase  = 2'(m_ph);
            x.done   = 1'b0;
            if (adv) begin
                if (m_ph == 0 && e) begin
                    if (m_el < G - 1) m_el = m_el + 1;
                end else if ((m_ph == 2 && e) || m_el == dur - 1) begin
                    m_ph   = (m_ph + 1) % 4;
                    m_el   = 0;
                    x.done = 1'b1;
                end else begin
                    m_el = m_el + 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic t, input logic p, input logic e);
        exp_t x;
        reset     = r;
        tick      = t;
        pause     = p;
        emergency = e;
        model(r, t, p, e, x);
        sb.push_back(x);
        @(posedge clock);
        #1;
        x = sb.pop_front();
        checks++;
        assert (status === x.status) else begin
            errors++;
            $error("FAIL sb_status observed=%h expected=%h", status, x.status);
        end
        checks++;
        assert (phase === x.phase) else begin
            errors++;
            $error("FAIL sb_phase observed=%0d expected=%0d", phase, x.phase);
        end
        checks++;
        assert (phase_done === x.done) else begin
            errors++;
            $error("FAIL sb_done observed=%0d expected=%0d", phase_done, x.done);
        end
        if (phase_done === 1'b1) done_seen++;
    endtask

    task automatic tick3(input logic p, input logic e);
        step(1'b0, 1'b1, p, e);
        step(1'b0, 1'b0, p, e);
        step(1'b0, 1'b0, p, e);
    endtask

    initial begin
        int dwell [4];
        int peak_cc;
        int d0;

        // Reset and first green phase
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            chk("reset_status", 32'(status), 32'd0);
            chk("reset_done", 32'(phase_done), 32'd0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("release_row", 32'(row_lights), 32'd1);
        chk("release_col", 32'(column_lights), 32'd4);
        chk("release_rc", 32'(row_count), 32'd0);
        chk("release_phase", 32'(phase), 32'd0);
        for (int i = 1; i <= G; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 1) chk("first_tick_rc", 32'(row_count), 32'd1);
        end
        chk("rc_28", 32'(row_count), 32'd28);
        chk("rc_28_done", 32'(phase_done), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t29_phase", 32'(phase), 32'd1);
        chk("t29_row", 32'(row_lights), 32'd2);

        // Free run: one full period
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) dwell[i] = 0;
        peak_cc = 0;
        d0 = done_seen;
        for (int i = 0; i < 2 * (G + Y); i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            dwell[phase] = dwell[phase] + 1;
            if (int'(column_count) > peak_cc) peak_cc = int'(column_count);
        end
        chk("dwell_row_g", 32'(dwell[0]), 32'd28);
        chk("dwell_row_y", 32'(dwell[1]), 32'd4);
        chk("dwell_col_g", 32'(dwell[2]), 32'd28);
        chk("dwell_col_y", 32'(dwell[3]), 32'd4);
        chk("period_done_pulses", 32'(done_seen - d0), 32'd4);
        chk("cc_peak", 32'(peak_cc), 32'd28);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("period_wrap_phase", 32'(phase), 32'd0);

        // Sparse ticks with a pause inside column green
        for (int i = 0; i < G + Y; i++) tick3(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick3(1'b0, 1'b0);
        chk("pre_pause_cc", 32'(column_count), 32'd5);
        for (int i = 0; i < 10; i++) begin
            tick3(1'b1, 1'b0);
            chk("pause_cc", 32'(column_count), 32'd5);
            chk("pause_phase", 32'(phase), 32'd2);
        end
        tick3(1'b0, 1'b0);
        chk("resume_cc", 32'(column_count), 32'd6);
        for (int i = 0; i < 21; i++) tick3(1'b0, 1'b0);
        chk("col_g_27", 32'(column_count), 32'd27);
        chk("col_g_27_phase", 32'(phase), 32'd2);
        tick3(1'b0, 1'b0);
        chk("col_g_exit_phase", 32'(phase), 32'd3);
        chk("col_g_exit_cc", 32'(column_count), 32'd0);

        // Emergency cuts column green short and parks row green
        for (int i = 0; i < Y + G + Y; i++) tick3(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick3(1'b0, 1'b0);
        chk("emg_start_cc", 32'(column_count), 32'd10);
        tick3(1'b0, 1'b1);
        chk("emg_cut_phase", 32'(phase), 32'd3);
        chk("emg_cut_cc", 32'(column_count), 32'd0);
        for (int i = 0; i < Y; i++) tick3(1'b0, 1'b1);
        chk("emg_row_g_phase", 32'(phase), 32'd0);
        d0 = done_seen;
        for (int i = 0; i < 50; i++) tick3(1'b0, 1'b1);
        chk("emg_hold_rc", 32'(row_count), 32'd28);
        chk("emg_hold_phase", 32'(phase), 32'd0);
        chk("emg_hold_no_done", 32'(done_seen - d0), 32'd0);
        tick3(1'b0, 1'b0);
        chk("emg_release_phase", 32'(phase), 32'd1);

        // Reset in the middle of row yellow
        tick3(1'b0, 1'b0);
        tick3(1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_reset_status", 32'(status), 32'd0);
        chk("mid_reset_phase", 32'(phase), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_release_status", 32'(status), 32'({3'b001, 3'b100, 8'd0, 8'd0}));

        // Pause dominates emergency
        for (int i = 0; i < G + Y + 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pe_start_cc", 32'(column_count), 32'd3);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            chk("pe_frozen_status", 32'(status), 32'({3'b100, 3'b001, 8'd0, 8'd3}));
            chk("pe_frozen_phase", 32'(phase), 32'd2);
            chk("pe_frozen_done", 32'(phase_done), 32'd0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("pe_release_done", 32'(phase_done), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pe_col_y_phase", 32'(phase), 32'd3);
        chk("pe_col_y_lights", 32'(column_lights), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
